// File: rtl/regfile_sb.sv
// regfile_sb: 2^AW x WIDTH register file with a per-register busy scoreboard.
// Two combinational read ports, one write port, one debug read port.
// Register 0 is hardwired to zero and can never be marked busy.
// Optional feature macro: REGFILE_SB_BYPASS_EN forwards same-cycle write data
// (and the write's busy release) onto rdata_a/rdata_b. dbg_data never bypasses.
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CE,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] busy_r;

    logic             wr_ok_s;
    logic             rsv_ok_s;
    logic [WIDTH-1:0] stored_a_s;
    logic [WIDTH-1:0] stored_b_s;
    logic             sbusy_a_s;
    logic             sbusy_b_s;

    // Qualified write/reserve strobes: gated by CE and never targeting r0.
    always_comb begin
        wr_ok_s  = CE && we  && (waddr    != {AW{1'b0}});
        rsv_ok_s = CE && rsv && (rsv_addr != {AW{1'b0}});
    end

    // Data storage: cleared asynchronously, written on qualified write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Scoreboard: writeback releases, reserve sets; reserve is applied last
    // so a same-address reserve (younger instruction) leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_ok_s) begin
                busy_r[waddr] <= 1'b0;
            end
            if (rsv_ok_s) begin
                busy_r[rsv_addr] <= 1'b1;
            end
        end
    end

    // Stored-state lookup for both read ports; r0 forced to zero / not busy.
    always_comb begin
        stored_a_s = {WIDTH{1'b0}};
        sbusy_a_s  = 1'b0;
        stored_b_s = {WIDTH{1'b0}};
        sbusy_b_s  = 1'b0;
        if (raddr_a != {AW{1'b0}}) begin
            stored_a_s = mem_r[raddr_a];
            sbusy_a_s  = busy_r[raddr_a];
        end else begin
            stored_a_s = {WIDTH{1'b0}};
            sbusy_a_s  = 1'b0;
        end
        if (raddr_b != {AW{1'b0}}) begin
            stored_b_s = mem_r[raddr_b];
            sbusy_b_s  = busy_r[raddr_b];
        end else begin
            stored_b_s = {WIDTH{1'b0}};
            sbusy_b_s  = 1'b0;
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic hit_a_s;
    logic hit_b_s;
    logic rsv_same_s;

    // Forwarding: a qualified write to the read address wins over storage;
    // busy follows the post-edge value (set only if reserved in the same cycle).
    always_comb begin
        hit_a_s    = wr_ok_s && (raddr_a == waddr);
        hit_b_s    = wr_ok_s && (raddr_b == waddr);
        rsv_same_s = rsv_ok_s && (rsv_addr == waddr);
        rdata_a    = hit_a_s ? wdata      : stored_a_s;
        busy_a     = hit_a_s ? rsv_same_s : sbusy_a_s;
        rdata_b    = hit_b_s ? wdata      : stored_b_s;
        busy_b     = hit_b_s ? rsv_same_s : sbusy_b_s;
    end
`else
    // Read ports driven purely from stored state.
    always_comb begin
        rdata_a = stored_a_s;
        busy_a  = sbusy_a_s;
        rdata_b = stored_b_s;
        busy_b  = sbusy_b_s;
    end
`endif

    // Debug port: stored state only, never forwarded.
    always_comb begin
        if (dbg_addr != {AW{1'b0}}) begin
            dbg_data = mem_r[dbg_addr];
        end else begin
            dbg_data = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected values into a
// queue, a monitor pops and compares on each falling clock edge (and on the
// rising edge of rst, to observe the asynchronous clear before any clk edge).
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    localparam logic [2:0] S_RDA = 3'd0;
    localparam logic [2:0] S_RDB = 3'd1;
    localparam logic [2:0] S_BSA = 3'd2;
    localparam logic [2:0] S_BSB = 3'd3;
    localparam logic [2:0] S_DBG = 3'd4;

    logic             clk;
    logic             rst;
    logic             CE;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             busy_a;
    logic             busy_b;
    logic             rsv;
    logic [AW-1:0]    rsv_addr;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] exp;
        logic [15:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   tag_cnt  = 0;

    regfile_sb #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .CE       (CE),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input logic [2:0] sel, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.exp = val;
        e.tag = tag_cnt[15:0];
        tag_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic string sel_name(input logic [2:0] sel);
        case (sel)
            S_RDA:   return "rdata_a";
            S_RDB:   return "rdata_b";
            S_BSA:   return "busy_a";
            S_BSB:   return "busy_b";
            S_DBG:   return "dbg_data";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.sel)
                    S_RDA:   act = rdata_a;
                    S_RDB:   act = rdata_b;
                    S_BSA:   act = {31'd0, busy_a};
                    S_BSB:   act = {31'd0, busy_b};
                    S_DBG:   act = dbg_data;
                    default: act = 32'hxxxx_xxxx;
                endcase
                chk_cnt++;
                if (act === e.exp) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL chk%0d %s: got 0x%08h expected 0x%08h",
                             e.tag, sel_name(e.sel), act, e.exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; CE = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        raddr_a = 5'd0; raddr_b = 5'd0; rsv = 1'b0; rsv_addr = 5'd0; dbg_addr = 5'd0;
        step();
        step();
        // Reset state
        raddr_a = 5'd7; raddr_b = 5'd5; dbg_addr = 5'd7;
        push_exp(S_RDA, 32'd0); push_exp(S_BSA, 32'd0);
        push_exp(S_RDB, 32'd0); push_exp(S_DBG, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Write r7, then async reset clears it before any clk edge
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        step();
        we = 1'b0;
        push_exp(S_RDA, 32'hDEAD_BEEF); push_exp(S_DBG, 32'hDEAD_BEEF);
        #6;
        push_exp(S_RDA, 32'd0); push_exp(S_BSA, 32'd0); push_exp(S_DBG, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_exp(S_RDA, 32'd0);
        step();

        // r0 is hardwired: write and reserve ignored
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
        rsv = 1'b1; rsv_addr = 5'd0; raddr_a = 5'd0;
        step();
        we = 1'b0; rsv = 1'b0;
        push_exp(S_RDA, 32'd0); push_exp(S_BSA, 32'd0);
        step();

        // Reserve r5 at edge N, write at edge N+3
        rsv = 1'b1; rsv_addr = 5'd5; raddr_b = 5'd5;
        push_exp(S_BSB, 32'd0);
        step();                                   // edge N
        rsv = 1'b0;
        push_exp(S_BSB, 32'd1);
        step();                                   // edge N+1
        push_exp(S_BSB, 32'd1);
        step();                                   // edge N+2
        we = 1'b1; waddr = 5'd5; wdata = 32'hA5A5_A5A5;
`ifdef REGFILE_SB_BYPASS_EN
        push_exp(S_BSB, 32'd0); push_exp(S_RDB, 32'hA5A5_A5A5);
`else
        push_exp(S_BSB, 32'd1); push_exp(S_RDB, 32'd0);
`endif
        step();                                   // edge N+3
        we = 1'b0;
        push_exp(S_BSB, 32'd0); push_exp(S_RDB, 32'hA5A5_A5A5);
        step();

        // Same-edge write and reserve to r9: data lands, busy ends set
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0055;
        rsv = 1'b1; rsv_addr = 5'd9; raddr_a = 5'd9;
        step();
        we = 1'b0; rsv = 1'b0;
        push_exp(S_RDA, 32'h0000_0055); push_exp(S_BSA, 32'd1);
        step();

        // Same-edge write r10 and reserve r11: independent
        we = 1'b1; waddr = 5'd10; wdata = 32'h0000_0010;
        rsv = 1'b1; rsv_addr = 5'd11;
        step();
        we = 1'b0; rsv = 1'b0; raddr_a = 5'd10; raddr_b = 5'd11;
        push_exp(S_RDA, 32'h0000_0010); push_exp(S_BSA, 32'd0);
        push_exp(S_RDB, 32'd0);         push_exp(S_BSB, 32'd1);
        step();

        // CE=0 discards write and reserve
        CE = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_00FF;
        rsv = 1'b1; rsv_addr = 5'd3;
        step();
        CE = 1'b1; we = 1'b0; rsv = 1'b0; dbg_addr = 5'd3; raddr_a = 5'd3;
        push_exp(S_DBG, 32'd0); push_exp(S_RDA, 32'd0); push_exp(S_BSA, 32'd0);
        step();

        // Same-cycle read of the register being written
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0001;
        step();
        wdata = 32'h0000_CAFE; raddr_a = 5'd12; dbg_addr = 5'd12;
`ifdef REGFILE_SB_BYPASS_EN
        push_exp(S_RDA, 32'h0000_CAFE);
`else
        push_exp(S_RDA, 32'h0000_0001);
`endif
        push_exp(S_DBG, 32'h0000_0001); push_exp(S_BSA, 32'd0);
        step();
        we = 1'b0;
        push_exp(S_RDA, 32'h0000_CAFE); push_exp(S_DBG, 32'h0000_CAFE);
        step();

        // Reset mid-operation: pending write/reserve lost
        we = 1'b1; waddr = 5'd13; wdata = 32'h0000_0077;
        rsv = 1'b1; rsv_addr = 5'd13;
        push_exp(S_RDA, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0; we = 1'b0; rsv = 1'b0; raddr_a = 5'd13; raddr_b = 5'd12;
        push_exp(S_RDA, 32'd0); push_exp(S_BSA, 32'd0); push_exp(S_RDB, 32'd0);
        step();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() > 0) begin
                @(negedge clk);
                #2;
            end
        end
        if (exp_q.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
